apuf_resp_ctrl: RTL and testbench
=================================

// Module: apuf_resp_ctrl
// PURPOSE
//  Launch-side and capture-side controller for one arbiter-PUF delay chain.
//  Accepts a challenge, drives it onto the switch-stage select lines, fires a
//  race edge into both chain inputs, samples the arbiter bit at the chain end,
//  repeats NEVAL times, and returns the majority-voted response bit.
//  Sits between the XOR-PUF top-level sequencer and each switch-chain/arbiter pair.
// PARAMETERS
//  NSTAGE  64  challenge width = number of switch stages
//  NEVAL   7   evaluations per challenge; odd, 1..255
//  TSET    4   cycles challenge is held stable before each launch
//  TCAP    8   cycles from launch rise to arbiter sample (>= chain delay + 2 sync)
//  TREL    4   cycles launch is held low after sample, before the next launch
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       challenge request valid
//  req_ready   out  1       controller can accept a challenge
//  chal_in     in   NSTAGE  challenge bits
//  chal_out    out  NSTAGE  registered challenge to switch-stage select inputs
//  race_launch out  1       race edge, drives top and bottom chain inputs
//  arb_in      in   1       raw arbiter output (asynchronous to clk)
//  resp_valid  out  1       response valid
//  resp_ready  in   1       consumer accepts response
//  resp_bit    out  1       majority-voted response
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; chal_out=0; race_launch=0; resp_valid=0;
//   resp_bit=0; busy=0; ones counter, eval counter and timer cleared.
//  Reset asserted mid-evaluation aborts immediately to reset values; no response is issued.
//  arb_in passes through a 2-flop synchroniser; only the synchronised value is sampled.
//  FSM states: IDLE -> SETTLE -> LAUNCH -> RELAX -> (SETTLE | DONE) -> IDLE.
//   IDLE:   req_ready=1. On req_valid&&req_ready, latch chal_in into chal_out,
//           clear counters, enter SETTLE.
//   SETTLE: race_launch=0, wait TSET cycles, enter LAUNCH.
//   LAUNCH: race_launch=1 for TCAP cycles. On the last cycle, sample the
//           synchronised arb_in and add it to the ones counter
//           (width $clog2(NEVAL+1)). Enter RELAX.
//   RELAX:  race_launch=0, wait TREL cycles, increment eval counter.
//           If count==NEVAL, enter DONE; otherwise enter SETTLE.
//   DONE:   resp_bit = (ones > NEVAL/2), registered on entry to DONE. resp_valid=1
//           and held, with resp_bit stable, until resp_valid&&resp_ready; then enter IDLE.
//  req_ready is 1 only in IDLE; req_valid outside IDLE is ignored (not queued).
//  chal_out is constant from accept until the next accept; it does not change in DONE.
//  resp_ready low in DONE: stall indefinitely, race_launch stays 0.
//  Latency: accept -> resp_valid = NEVAL*(TSET+TCAP+TREL)+1 cycles.
//  Timers count down from param-1 to 0; a parameter value of 0 is illegal.
//   Elaboration fails if NEVAL is even or any timing parameter is 0.
// CONFIGURATION
//  Macro APUF_SOFT_RESP_EN:
//   Defined: adds output resp_ones [$clog2(NEVAL+1)-1:0], the raw ones count,
//    valid with resp_valid; reset value 0. Used for reliability/soft-decision
//    characterisation.
//   Undefined: the port and its register are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package apuf_pkg: FSM state enum (IDLE, SETTLE, LAUNCH, RELAX, DONE),
//   default timing constants, and a ones-counter width function.
//  One sub-module: apuf_sync2, the 2-flop synchroniser for arb_in (reset to 0).
//  Switch chain and arbiter stay outside this block and are instantiated by the parent.
// TESTING
//  1 Defaults. Behavioural chain model with arb_in always 1; chal_in=64'hA5A5_0000_FFFF_1234
//    -> chal_out matches; resp_bit=1; resp_valid exactly 113 cycles after accept.
//  2 arb_in pattern 1,0,1,0,0,1,0 across the 7 evaluations -> ones=3, resp_bit=0;
//    with APUF_SOFT_RESP_EN defined, resp_ones=3.
//  3 Hold resp_ready=0 for 20 cycles in DONE -> resp_valid and resp_bit stable,
//    race_launch=0, req_ready=0; releasing resp_ready returns to IDLE in 1 cycle.
//  4 Pulse rst_n low during the 3rd LAUNCH -> all outputs at reset values at once;
//    no resp_valid; a new request afterwards runs normally.
//  5 Assert req_valid during SETTLE with a new challenge -> ignored; chal_out unchanged.
//  6 Set NEVAL=1, TSET=TCAP=TREL=1 -> race_launch high for exactly 1 cycle;
//    resp_valid 4 cycles after accept; resp_bit equals the sampled arb_in.

Source files
------------

// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF response controller.
//   apuf_state_t : controller FSM states
//   DEF_*        : default geometry and timing constants
//   ones_width   : width of a counter able to hold 0..neval
//   timer_width  : width of a down-counter able to hold (max timing param - 1)
package apuf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    RELAX,
    DONE
  } apuf_state_t;

  localparam int unsigned DEF_NSTAGE = 64;
  localparam int unsigned DEF_NEVAL  = 7;
  localparam int unsigned DEF_TSET   = 4;
  localparam int unsigned DEF_TCAP   = 8;
  localparam int unsigned DEF_TREL   = 4;

  function automatic int unsigned ones_width(input int unsigned neval);
    return (neval < 1) ? 1 : $clog2(neval + 1);
  endfunction

  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/apuf_sync2.sv
// Two-flop synchroniser for the asynchronous arbiter output.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   d     : asynchronous input
//   q     : synchronised output
module apuf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/apuf_resp_ctrl.sv
// Launch/capture controller for one arbiter-PUF delay chain. Latches a
// challenge, fires NEVAL race edges (settle / launch / relax per evaluation),
// counts arbiter ones and returns the majority-voted response bit.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : challenge handshake, chal_in [NSTAGE]
//   chal_out               : registered challenge to switch-stage selects
//   race_launch            : race edge into both chain inputs
//   arb_in                 : raw arbiter output (asynchronous)
//   resp_valid/resp_ready  : response handshake, resp_bit = majority vote
//   busy                   : high whenever not IDLE
// Option macro APUF_SOFT_RESP_EN adds output resp_ones (raw ones count).
module apuf_resp_ctrl
  import apuf_pkg::*;
#(
  parameter int unsigned NSTAGE = DEF_NSTAGE,
  parameter int unsigned NEVAL  = DEF_NEVAL,
  parameter int unsigned TSET   = DEF_TSET,
  parameter int unsigned TCAP   = DEF_TCAP,
  parameter int unsigned TREL   = DEF_TREL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NSTAGE-1:0] chal_in,
  output logic [NSTAGE-1:0] chal_out,
  output logic              race_launch,
  input  logic              arb_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
`ifdef APUF_SOFT_RESP_EN
  output logic [ones_width(NEVAL)-1:0] resp_ones,
`endif
  output logic              busy
);

  localparam int unsigned OW = ones_width(NEVAL);
  localparam int unsigned TW = timer_width(TSET, TCAP, TREL);

  if ((NEVAL % 2) == 0 || NEVAL > 255 || TSET == 0 || TCAP == 0 || TREL == 0 ||
      NSTAGE == 0) begin : g_bad_param
    $error("apuf_resp_ctrl: NEVAL must be odd 1..255 and timing parameters nonzero");
  end

  apuf_state_t   state, next_state;
  logic [TW-1:0] timer;
  logic [OW-1:0] ones_cnt;
  logic [OW-1:0] eval_cnt;
  logic          arb_sync;
  logic          last_eval;
  logic          timer_zero;

  apuf_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (arb_in),
    .q     (arb_sync)
  );

  assign timer_zero = (timer == '0);
  assign last_eval  = (eval_cnt == OW'(NEVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) next_state = SETTLE;
      end
      SETTLE: if (timer_zero) next_state = LAUNCH;
      LAUNCH: if (timer_zero) next_state = RELAX;
      RELAX:  if (timer_zero) next_state = last_eval ? DONE : SETTLE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // race_launch comes straight from a flop (glitch-free into the chain);
  // registering next_state==LAUNCH keeps it aligned with the LAUNCH state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      race_launch <= 1'b0;
      chal_out    <= '0;
      timer       <= '0;
      ones_cnt    <= '0;
      eval_cnt    <= '0;
      resp_bit    <= 1'b0;
`ifdef APUF_SOFT_RESP_EN
      resp_ones   <= '0;
`endif
    end else begin
      race_launch <= (next_state == LAUNCH);
      case (state)
        IDLE: begin
          if (req_valid) begin
            chal_out <= chal_in;
            ones_cnt <= '0;
            eval_cnt <= '0;
            timer    <= TW'(TSET - 1);
          end
        end
        SETTLE: begin
          if (timer_zero) timer <= TW'(TCAP - 1);
          else            timer <= timer - TW'(1);
        end
        LAUNCH: begin
          if (timer_zero) begin
            timer    <= TW'(TREL - 1);
            ones_cnt <= ones_cnt + OW'(arb_sync);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RELAX: begin
          if (timer_zero) begin
            eval_cnt <= eval_cnt + OW'(1);
            timer    <= TW'(TSET - 1);
            if (last_eval) begin
              resp_bit  <= (ones_cnt > OW'(NEVAL / 2));
`ifdef APUF_SOFT_RESP_EN
              resp_ones <= ones_cnt;
`endif
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apuf_resp_ctrl.sv
// Directed self-checking bench for apuf_resp_ctrl: a default instance
// (64 stages, 7 evaluations, 4/8/4 timing) and a minimal instance
// (NEVAL=1, all timers 1). Inputs are driven and outputs sampled on the
// falling clock edge. Latency is counted as the number of clock cycles from
// the accept cycle to the first cycle in which resp_valid is high.
module tb_apuf_resp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, race_launch, arb_in;
  logic        resp_valid, resp_ready, resp_bit, busy;
  logic [63:0] chal_in, chal_out;

  logic        req_valid1, req_ready1, race_launch1, arb_in1;
  logic        resp_valid1, resp_ready1, resp_bit1, busy1;
  logic [63:0] chal_in1, chal_out1;

`ifdef APUF_SOFT_RESP_EN
  logic [2:0]  resp_ones;
  logic [0:0]  resp_ones1;
`endif

  apuf_resp_ctrl u_dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready),
    .chal_in (chal_in), .chal_out (chal_out),
    .race_launch (race_launch), .arb_in (arb_in),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_bit (resp_bit),
`ifdef APUF_SOFT_RESP_EN
    .resp_ones (resp_ones),
`endif
    .busy (busy)
  );

  apuf_resp_ctrl #(.NEVAL(1), .TSET(1), .TCAP(1), .TREL(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid1), .req_ready (req_ready1),
    .chal_in (chal_in1), .chal_out (chal_out1),
    .race_launch (race_launch1), .arb_in (arb_in1),
    .resp_valid (resp_valid1), .resp_ready (resp_ready1),
    .resp_bit (resp_bit1),
`ifdef APUF_SOFT_RESP_EN
    .resp_ones (resp_ones1),
`endif
    .busy (busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   req_ready,   1'b1);
    check({tag, "_chal_out"},    chal_out,    64'h0);
    check({tag, "_race_launch"}, race_launch, 1'b0);
    check({tag, "_resp_valid"},  resp_valid,  1'b0);
    check({tag, "_resp_bit"},    resp_bit,    1'b0);
    check({tag, "_busy"},        busy,        1'b0);
`ifdef APUF_SOFT_RESP_EN
    check({tag, "_resp_ones"},   resp_ones,   3'd0);
`endif
  endtask

  // Issue one challenge to the default instance; arb_in follows pat[k] for
  // evaluation k (updated when race_launch falls). Optionally injects a
  // second request (inverted challenge) during the first SETTLE.
  task automatic do_request(input logic [63:0] chal, input logic [6:0] pat,
                            input bit inject, output int lat, output int lcyc);
    int  eidx;
    logic prev;
    @(negedge clk);
    arb_in    = pat[0];
    chal_in   = chal;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    lat = 1; lcyc = 0; eidx = 0; prev = 1'b0;
    req_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    if (inject) begin
      check("req_ready_settle", req_ready, 1'b0);
      req_valid = 1'b1;
      chal_in   = ~chal;
    end
    while (!resp_valid && lat < 400) begin
      if (inject && lat == 3) req_valid = 1'b0;
      if (race_launch) lcyc++;
      if (prev && !race_launch && eidx < 6) begin
        eidx++;
        arb_in = pat[eidx];
      end
      prev = race_launch;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    check("resp_valid_seen", resp_valid, 1'b1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("idle_resp_valid", resp_valid, 1'b0);
    check("idle_req_ready",  req_ready,  1'b1);
    check("idle_busy",       busy,       1'b0);
  endtask

  task automatic run_small(input logic arb, output int lat, output int lcyc);
    arb_in1 = arb;
    repeat (3) @(negedge clk);
    req_valid1 = 1'b1;
    chal_in1   = 64'h0123_4567_89AB_CDEF;
    check("small_req_ready", req_ready1, 1'b1);
    @(negedge clk);
    req_valid1 = 1'b0;
    lat = 1; lcyc = 0;
    while (!resp_valid1 && lat < 50) begin
      if (race_launch1) lcyc++;
      @(negedge clk);
      lat++;
    end
    check("small_resp_valid", resp_valid1, 1'b1);
  endtask

  localparam logic [63:0] C1 = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] C2 = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] C4 = 64'hDEAD_BEEF_0F0F_5A5A;

  initial begin
    int  lat, lcyc, nl, k;
    logic prev, seen;

    rst_n = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0; arb_in = 1'b0; chal_in = '0;
    req_valid1 = 1'b0; resp_ready1 = 1'b0; arb_in1 = 1'b0; chal_in1 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Pattern 1,0,1,0,0,1,0 -> 3 ones; extra request during SETTLE; stall
    do_request(C2, 7'b0100101, 1'b1, lat, lcyc);
    check("pat_latency",  lat,      113);
    check("pat_launches", lcyc,     56);
    check("pat_resp_bit", resp_bit, 1'b0);
    check("inject_chal",  chal_out, C2);
`ifdef APUF_SOFT_RESP_EN
    check("pat_resp_ones", resp_ones, 3'd3);
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_resp_valid",  resp_valid,  1'b1);
      check("stall_resp_bit",    resp_bit,    1'b0);
      check("stall_race_launch", race_launch, 1'b0);
      check("stall_req_ready",   req_ready,   1'b0);
      check("stall_chal_out",    chal_out,    C2);
    end
    finish_resp();

    // All-ones arbiter -> response 1, latency 7*16+1
    do_request(C1, 7'h7F, 1'b0, lat, lcyc);
    check("ones_latency",  lat,      113);
    check("ones_launches", lcyc,     56);
    check("ones_resp_bit", resp_bit, 1'b1);
    check("ones_chal_out", chal_out, C1);
`ifdef APUF_SOFT_RESP_EN
    check("ones_resp_ones", resp_ones, 3'd7);
`endif
    finish_resp();
    check("idle_chal_hold", chal_out, C1);

    // Reset pulse at the start of the third LAUNCH
    @(negedge clk);
    arb_in = 1'b1; chal_in = C4; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    nl = 0; k = 0; prev = 1'b0;
    while (k < 200) begin
      if (race_launch && !prev) nl++;
      if (nl == 3) break;
      prev = race_launch;
      @(negedge clk);
      k++;
    end
    check("third_launch_reached", nl, 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("abort_no_resp", seen, 1'b0);
    do_request(C4, 7'h7F, 1'b0, lat, lcyc);
    check("post_abort_latency",  lat,      113);
    check("post_abort_resp_bit", resp_bit, 1'b1);
    check("post_abort_chal_out", chal_out, C4);
    finish_resp();

    // Minimal configuration
    run_small(1'b1, lat, lcyc);
    check("small1_latency",  lat,       4);
    check("small1_launches", lcyc,      1);
    check("small1_resp_bit", resp_bit1, 1'b1);
`ifdef APUF_SOFT_RESP_EN
    check("small1_resp_ones", resp_ones1, 1'b1);
`endif
    resp_ready1 = 1'b1;
    @(negedge clk);
    resp_ready1 = 1'b0;
    check("small_idle", req_ready1, 1'b1);
    run_small(1'b0, lat, lcyc);
    check("small0_latency",  lat,       4);
    check("small0_resp_bit", resp_bit1, 1'b0);
    resp_ready1 = 1'b1;
    @(negedge clk);
    resp_ready1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
